imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage of the RISC-V core. It resolves the immediate format either from an explicit type code or automatically from the opcode. It also supports CSR zimm, shift-amount immediates and XLEN of 32 or 64. Results sit behind a 2-entry valid/ready buffer, so decode can stall against execute without losing instructions.

## Interface
- XLEN, 32, output datapath width; legal values 32 or 64.
- TAG_W, 8, width of an opaque sideband tag (PC index / ROB id) carried with each instruction.
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; empties the buffer at the next edge.
- in_valid  in  1  input beat valid.
- in_ready  out  1  buffer can accept a beat.
- in_inst  in  32  raw instruction word.
- in_type  in  3  format: 000 none, 001 I, 010 B, 011 S, 100 J, 101 U, 110 Z (CSR zimm), 111 auto.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_imm  out  XLEN  immediate, extended to XLEN.
- out_type  out  3  resolved format (never 111).
- out_tag  out  TAG_W  tag of the output beat.
- out_illegal  out  1  auto mode found an unrecognised opcode.

## Operation
- Decode is combinational on the input side; the results (imm, type, tag, illegal) are written into the buffer entry.
- Immediate formats:
  - I = sext(inst[31:20]).
  - S = sext({inst[31:25], inst[11:7]}).
  - B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - U = sext({inst[31:12], 12'h0}).
  - Z = zext(inst[19:15]).
  - none = 0.
  - sext/zext extend to XLEN.
- Auto mode (in_type = 111), keyed on inst[6:0]:
  - 0000011 and 1100111 → I.
  - 0010011 → I, except funct3 001/101, which give shift form: zext(inst[24:20]) if XLEN=32, zext(inst[25:20]) if XLEN=64; out_type 001.
  - 1110011 → Z if funct3[2]=1, otherwise I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111 and 0010111 → U.
  - Any other opcode → out_type 000, out_imm 0, out_illegal 1.
- Explicit types are applied verbatim (no shift special case). out_illegal is 0 for explicit types.
- Buffer: 2-entry FIFO with head/tail pointers and a 2-bit count.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != 2). It depends only on registers, with no combinational path from out_ready.
  - out_valid = (count != 0). The out_* fields come from the head entry.
- Simultaneous push and pop at count 1: count stays 1, order is preserved.
- Push while full cannot occur, since in_ready=0.
- flush has priority over push and pop: count→0 and pointers→0 at the next edge. A beat offered in the flush cycle is dropped.
- While out_valid=1 and out_ready=0, all out_* fields hold stable.

## Timing
- Reset (rstn low, asynchronous):
  - count, pointers, and all entry storage → 0.
  - Outputs: out_valid 0, out_imm 0, out_type 000, out_tag 0, out_illegal 0, in_ready 1.
  - Reset asserted mid-operation discards all buffered beats immediately.
- Latency: a beat accepted at edge N appears with out_valid=1 immediately after edge N (1 cycle).
- Throughput is 1 beat/cycle with out_ready held high.
- After a flush edge, out_valid=0 and in_ready=1.

## Test plan
- XLEN=32, auto type, inst 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, out_imm 0xFFFFFFFF, out_type 001, out_illegal 0.
- XLEN=32, auto types:
  - 0xFE000EE3 (beq -4) → imm 0xFFFFFFFC, type 010.
  - 0x300FD073 (csrrwi x0,mstatus,31) → imm 0x0000001F, type 110.
  - 0x0000007F → type 000, imm 0, illegal 1.
- XLEN=64, auto types:
  - 0x80000537 (lui) → imm 0xFFFFFFFF80000000, type 101.
  - 0x03F09093 (slli x1,x1,63) → imm 0x000000000000003F, type 001.
- Backpressure: out_ready=0, offer tags 1,2,3 back-to-back → in_ready drops to 0 after 2 accepts, tag 3 held; raise out_ready → outputs tags 1,2,3 in order, one per cycle, no loss or duplication.
- Flush: count=2, assert flush with in_valid=1 (tag 9) → next cycle out_valid=0, in_ready=1, tag 9 never appears.
- Reset mid-stream: drop rstn with count=1 → out_valid=0 asynchronously. After release, a new beat has 1-cycle latency, and there are no stale tags.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V decode-stage immediate generator: explicit or opcode-derived format, CSR zimm, shamt.
// One cycle of latency through a 2-entry valid/ready buffer; in_ready is registered-only and drops when both entries are held.

module imm_gen_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   count;
  logic         push, pop;

  assign in_rdy  = (count != 2'd2);
  assign out_vld = (count != 2'd0);
  assign out_dat = mem[rd_ptr];
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_I    = 3'b001;
  localparam logic [2:0] T_B    = 3'b010;
  localparam logic [2:0] T_S    = 3'b011;
  localparam logic [2:0] T_J    = 3'b100;
  localparam logic [2:0] T_U    = 3'b101;
  localparam logic [2:0] T_Z    = 3'b110;
  localparam logic [2:0] T_AUTO = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } meta_t;

  meta_t      dec_d, head_q;
  logic [2:0] res_type;
  logic       is_shamt;
  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  always_comb begin
    res_type      = in_type;
    is_shamt      = 1'b0;
    dec_d.illegal = 1'b0;
    if (in_type == T_AUTO) begin
      case (opcode)
        7'b0000011, 7'b1100111: res_type = T_I;
        7'b0010011: begin
          res_type = T_I;
          is_shamt = (funct3 == 3'b001) || (funct3 == 3'b101);
        end
        7'b1110011:             res_type = funct3[2] ? T_Z : T_I;
        7'b0100011:             res_type = T_S;
        7'b1100011:             res_type = T_B;
        7'b1101111:             res_type = T_J;
        7'b0110111, 7'b0010111: res_type = T_U;
        default: begin
          res_type      = T_NONE;
          dec_d.illegal = 1'b1;
        end
      endcase
    end
  end

  // Shift immediates override the I form; only reachable from auto mode.
  always_comb begin
    case (res_type)
      T_I:     dec_d.imm = XLEN'($signed(in_inst[31:20]));
      T_S:     dec_d.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      T_B:     dec_d.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      T_J:     dec_d.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      T_U:     dec_d.imm = XLEN'($signed({in_inst[31:12], 12'h000}));
      T_Z:     dec_d.imm = XLEN'(in_inst[19:15]);
      default: dec_d.imm = '0;
    endcase
    if (is_shamt)
      dec_d.imm = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
  end

  assign dec_d.typ = res_type;
  assign dec_d.tag = in_tag;

  imm_gen_fifo2 #(.W($bits(meta_t))) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .in_vld  (in_valid),
    .in_rdy  (in_ready),
    .in_dat  (dec_d),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (head_q)
  );

  assign out_imm     = head_q.imm;
  assign out_type    = head_q.typ;
  assign out_tag     = head_q.tag;
  assign out_illegal = head_q.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives XLEN=32 and XLEN=64 instances in lockstep and scores both against an arithmetic reference model.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_type;
  logic [7:0]  in_tag;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_type32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_type64;
  logic [7:0]  out_tag64;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  typ;
    logic [7:0]  tag;
    logic        ill;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_type(out_type32), .out_tag(out_tag32),
    .out_illegal(out_illegal32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_type(out_type64), .out_tag(out_tag64),
    .out_illegal(out_illegal64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    return (v >= (64'sd1 <<< (bits - 1))) ? v - (64'sd1 <<< bits) : v;
  endfunction

  // Immediate value as a mathematical integer, then truncated to xlen.
  function automatic void ref_model(input int xlen, input logic [31:0] inst, input logic [2:0] t,
                                    output logic [63:0] imm, output logic [2:0] rt, output logic ill);
    longint v;
    bit shift = 0;
    int op = int'(inst[6:0]);
    int f3 = int'(inst[14:12]);
    rt = t;
    ill = 0;
    if (t == 3'd7) begin
      case (op)
        'h03, 'h67: rt = 3'd1;
        'h13: begin rt = 3'd1; shift = (f3 == 1) || (f3 == 5); end
        'h73: rt = (f3 >= 4) ? 3'd6 : 3'd1;
        'h23: rt = 3'd3;
        'h63: rt = 3'd2;
        'h6F: rt = 3'd4;
        'h37, 'h17: rt = 3'd5;
        default: begin rt = 3'd0; ill = 1; end
      endcase
    end
    case (rt)
      3'd1: v = sx(longint'(inst[31:20]), 12);
      3'd3: v = sx(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
      3'd2: v = sx(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
                   longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
      3'd4: v = sx(longint'(inst[31]) * (1 << 20) + longint'(inst[19:12]) * 4096 +
                   longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
      3'd5: v = sx(longint'(inst[31:12]) * 4096, 32);
      3'd6: v = longint'(inst[19:15]);
      default: v = 0;
    endcase
    if (shift) v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
    imm = (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  // Check outputs at the negedge, then advance the model across the next posedge.
  task automatic step();
    exp_t e;
    logic [2:0] t64;
    logic i64;
    bit push, pop;
    @(negedge clk);
    chk("in_ready32", in_ready32, q.size() != 2);
    chk("in_ready64", in_ready64, q.size() != 2);
    chk("out_valid32", out_valid32, q.size() != 0);
    chk("out_valid64", out_valid64, q.size() != 0);
    if (q.size() != 0) begin
      chk("imm32", out_imm32, q[0].imm32);
      chk("imm64", out_imm64, q[0].imm64);
      chk("type32", out_type32, q[0].typ);
      chk("type64", out_type64, q[0].typ);
      chk("tag32", out_tag32, q[0].tag);
      chk("tag64", out_tag64, q[0].tag);
      chk("ill32", out_illegal32, q[0].ill);
      chk("ill64", out_illegal64, q[0].ill);
    end
    ref_model(32, in_inst, in_type, e.imm32, e.typ, e.ill);
    ref_model(64, in_inst, in_type, e.imm64, t64, i64);
    e.tag = in_tag;
    push = in_valid && (q.size() != 2);
    pop  = out_ready && (q.size() != 0);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [2:0] t, input logic [7:0] tag);
    in_valid = 1'b1;
    in_inst  = inst;
    in_type  = t;
    in_tag   = tag;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    for (int i = 0; i < 8 && q.size() != 0; i++) step();
    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL drain_timeout observed=%0d expected=0", q.size());
    end
  endtask

  logic [6:0] ops [10] = '{7'h03, 7'h67, 7'h13, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};

  initial begin
    logic [31:0] r;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_type = '0; in_tag = '0;
    #1;
    chk("rst_valid32", out_valid32, 0);
    chk("rst_valid64", out_valid64, 0);
    chk("rst_ready32", in_ready32, 1);
    chk("rst_imm32", out_imm32, 0);
    chk("rst_imm64", out_imm64, 0);
    chk("rst_type", out_type64, 0);
    chk("rst_tag", out_tag32, 0);
    chk("rst_ill", out_illegal64, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed auto-mode vectors, consumer always ready.
    out_ready = 1'b1;
    offer(32'hFFF00093, 3'd7, 8'h10); step();
    offer(32'hFE000EE3, 3'd7, 8'h11); step();
    offer(32'h300FD073, 3'd7, 8'h12); step();
    offer(32'h0000007F, 3'd7, 8'h13); step();
    offer(32'h80000537, 3'd7, 8'h14); step();
    offer(32'h03F09093, 3'd7, 8'h15); step();
    offer(32'h03F09093, 3'd1, 8'h16); step();
    offer(32'hFFFFF0EF, 3'd4, 8'h17); step();
    offer(32'hFE1FAF23, 3'd3, 8'h18); step();
    offer(32'h12345678, 3'd0, 8'h19); step();
    drain();
    // First-transaction sanity against literal values from the plan.
    offer(32'hFFF00093, 3'd7, 8'h20); step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi_imm32", out_imm32, 64'hFFFF_FFFF);
    chk("addi_type", out_type32, 3'b001);
    @(posedge clk); #1;
    void'(q.pop_front());

    // Backpressure: three back-to-back offers with the consumer stalled.
    out_ready = 1'b0;
    offer(32'h00100093, 3'd7, 8'd1); step();
    offer(32'h00200093, 3'd7, 8'd2); step();
    offer(32'h00300093, 3'd7, 8'd3); step();
    step();
    out_ready = 1'b1;
    step();
    step();
    drain();

    // Flush with a full buffer drops the beat offered in the same cycle.
    out_ready = 1'b0;
    offer(32'h00700093, 3'd7, 8'd7); step();
    offer(32'h00800093, 3'd7, 8'd8); step();
    offer(32'h00900093, 3'd7, 8'd9); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    // Asynchronous reset with one beat buffered.
    out_ready = 1'b0;
    offer(32'h00A00093, 3'd7, 8'hAA); step();
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("async_valid32", out_valid32, 0);
    chk("async_valid64", out_valid64, 0);
    chk("async_ready", in_ready64, 1);
    chk("async_tag", out_tag32, 0);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    offer(32'h00B00093, 3'd7, 8'h55); step();
    in_valid = 1'b0; step();
    drain();

    // Randomized traffic with occasional flushes and stalls.
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 9)];
      offer(r, ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 6)) : 3'd7, 8'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
